// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: default parameter
// values and the clear-sequencer state encoding.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_ADDR_W   = 5;
    localparam int unsigned DEF_NRD      = 2;
    localparam int unsigned DEF_ZERO_REG = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: blanking during clear, hardwired-zero
// entry 0, and write-first bypass from both write ports (port 1 wins).
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              busy,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata
);

    localparam bit ZR = (ZERO_REG != 0);

    // Priority: clear blanking, zero register, port-1 bypass, port-0 bypass, storage
    always_comb begin
        rdata = mem_data;
        if (busy) begin
            rdata = '0;
        end else if (ZR && (raddr == '0)) begin
            rdata = '0;
        end else if (we1 && (waddr1 == raddr)) begin
            rdata = wdata1;
        end else if (we0 && (waddr0 == raddr)) begin
            rdata = wdata0;
        end
    end

endmodule

// File: rtl/multiport_reg_file.sv
// Register file with two write ports, NRD combinational read ports and a
// sequential clear engine that zeroes one entry per cycle (also run on reset).
module multiport_reg_file
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NRD      = DEF_NRD,
    parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam bit          ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [DEPTH];

    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic              done_nxt;
    logic              wen0, wen1;

    // Clear sequencer state, index and done pulse; reset starts a full clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= CLEAR;
            idx      <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            clr_done <= done_nxt;
        end
    end

    // Next-state logic: clr_req only honoured in IDLE, CLEAR walks idx to the top
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        clr_busy  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                idx_nxt  = idx + 1'b1;
                if (idx == '1) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = CLEAR;
                idx_nxt   = '0;
            end
        endcase
    end

    // Effective write enables: blocked during clear and for the zero register
    always_comb begin
        wen0 = we0 && !clr_busy && !(ZR && (waddr0 == '0));
        wen1 = we1 && !clr_busy && !(ZR && (waddr1 == '0));
    end

    // Storage update; port 1 is written last so it wins on an address collision
    always_ff @(posedge clk) begin
        if (clr_busy) begin
            mem[idx] <= '0;
        end else begin
            if (wen0) mem[waddr0] <= wdata0;
            if (wen1) mem[waddr1] <= wdata1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_rd_port (
            .raddr   (raddr[k*ADDR_W +: ADDR_W]),
            .mem_data(mem[raddr[k*ADDR_W +: ADDR_W]]),
            .busy    (clr_busy),
            .we0     (we0),
            .waddr0  (waddr0),
            .wdata0  (wdata0),
            .we1     (we1),
            .waddr1  (waddr1),
            .wdata1  (wdata1),
            .rdata   (rdata[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_multiport_reg_file.sv
// Directed testbench for multiport_reg_file: reset auto-clear, write/bypass,
// dual-write collision, zero register (both settings), clr_req, reset mid-clear.
module tb_multiport_reg_file;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NRD   = 2;
    localparam int unsigned DEPTH = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              we0, we1, clr_req;
    logic [AW-1:0]     waddr0, waddr1;
    logic [DW-1:0]     wdata0, wdata1;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata, rdata_nz;
    logic              clr_busy, clr_done, busy_nz, done_nz;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    multiport_reg_file #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NRD     (NRD),
        .ZERO_REG(1)
    ) dut (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    multiport_reg_file #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NRD     (NRD),
        .ZERO_REG(0)
    ) dut_nz (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_nz),
        .clr_req(clr_req), .clr_busy(busy_nz), .clr_done(done_nz)
    );

    task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic writes_off();
        we0 = 1'b0; we1 = 1'b0;
        waddr0 = '0; waddr1 = '0;
        wdata0 = '0; wdata1 = '0;
    endtask

    task automatic test_reset();
        int busy_cnt = 0;
        int done_cnt = 0;
        reset = 1'b0;
        clr_req = 1'b0;
        writes_off();
        set_raddr(5'd0, 5'd0);
        repeat (3) @(negedge clk);
        checks++;
        if (clr_busy !== 1'b1 || clr_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b expected busy=1 done=0", clr_busy, clr_done);
        end
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!clr_busy) break;
            busy_cnt++;
            if (i == 5) begin
                set_raddr(5'd3, 5'd9);
                #1;
                checks++;
                if (rdata !== '0) begin
                    fails++;
                    $display("FAIL reset_clear_read: got %h expected 0", rdata);
                end
            end
            @(negedge clk);
            if (clr_done) done_cnt++;
        end
        checks++;
        if (busy_cnt != 32) begin
            fails++;
            $display("FAIL reset_busy_cycles: got %0d expected 32", busy_cnt);
        end
        @(negedge clk);
        if (clr_done) done_cnt++;
        checks++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL reset_done_pulses: got %0d expected 1", done_cnt);
        end
        for (int unsigned a = 0; a < DEPTH; a++) begin
            set_raddr(AW'(a), AW'(DEPTH - 1 - a));
            #1;
            checks++;
            if (rdata !== '0 || rdata_nz !== '0) begin
                fails++;
                $display("FAIL reset_entry_zero[%0d]: got %h / %h expected 0", a, rdata, rdata_nz);
            end
        end
    endtask

    task automatic test_write_bypass();
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        set_raddr(5'd5, 5'd5);
        #1;
        checks++;
        if (rdata !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL bypass_read5: got %h expected deadbeefdeadbeef", rdata);
        end
        @(negedge clk);
        writes_off();
        set_raddr(5'd5, 5'd6);
        #1;
        checks++;
        if (rdata[DW-1:0] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL stored_read5: got %h expected deadbeef", rdata[DW-1:0]);
        end
        checks++;
        if (rdata[2*DW-1:DW] !== 32'h0) begin
            fails++;
            $display("FAIL untouched_read6: got %h expected 0", rdata[2*DW-1:DW]);
        end
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2;
        set_raddr(5'd7, 5'd7);
        #1;
        checks++;
        if (rdata[DW-1:0] !== 32'h2) begin
            fails++;
            $display("FAIL collide_bypass7: got %h expected 2", rdata[DW-1:0]);
        end
        @(negedge clk);
        writes_off();
        #1;
        checks++;
        if (rdata[DW-1:0] !== 32'h2) begin
            fails++;
            $display("FAIL collide_stored7: got %h expected 2", rdata[DW-1:0]);
        end
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5A5A5A5;
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h5A5A5A5A;
        set_raddr(5'd3, 5'd4);
        #1;
        checks++;
        if (rdata !== {32'h5A5A5A5A, 32'hA5A5A5A5}) begin
            fails++;
            $display("FAIL split_bypass: got %h expected 5a5a5a5aa5a5a5a5", rdata);
        end
        @(negedge clk);
        writes_off();
        #1;
        checks++;
        if (rdata !== {32'h5A5A5A5A, 32'hA5A5A5A5}) begin
            fails++;
            $display("FAIL split_stored: got %h expected 5a5a5a5aa5a5a5a5", rdata);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h55;
        set_raddr(5'd0, 5'd0);
        #1;
        checks++;
        if (rdata[DW-1:0] !== 32'h0) begin
            fails++;
            $display("FAIL zero_bypass: got %h expected 0", rdata[DW-1:0]);
        end
        checks++;
        if (rdata_nz[DW-1:0] !== 32'h55) begin
            fails++;
            $display("FAIL nz_bypass: got %h expected 55", rdata_nz[DW-1:0]);
        end
        @(negedge clk);
        writes_off();
        #1;
        checks++;
        if (rdata !== '0) begin
            fails++;
            $display("FAIL zero_stored: got %h expected 0", rdata);
        end
        checks++;
        if (rdata_nz !== {32'h55, 32'h55}) begin
            fails++;
            $display("FAIL nz_stored: got %h expected 0000005500000055", rdata_nz);
        end
    endtask

    task automatic test_clear_req();
        int busy_cnt = 0;
        for (int unsigned a = 1; a < DEPTH; a++) begin
            @(negedge clk);
            we0 = 1'b1; waddr0 = AW'(a); wdata0 = 32'h1000 + a;
        end
        @(negedge clk);
        writes_off();
        set_raddr(5'd1, 5'd31);
        #1;
        checks++;
        if (rdata !== {32'h101F, 32'h1001}) begin
            fails++;
            $display("FAIL fill_readback: got %h expected 0000101f00001001", rdata);
        end
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!clr_busy) break;
            busy_cnt++;
            if (i < 20) begin
                we0 = 1'b1; waddr0 = 5'd1;  wdata0 = 32'hFFFFFFFF;
                we1 = 1'b1; waddr1 = 5'd31; wdata1 = 32'hEEEEEEEE;
                set_raddr(5'd1, 5'd31);
                #1;
                checks++;
                if (rdata !== '0) begin
                    fails++;
                    $display("FAIL clear_read_blank[%0d]: got %h expected 0", i, rdata);
                end
            end else begin
                writes_off();
            end
            clr_req = (i == 10);
            @(negedge clk);
        end
        clr_req = 1'b0;
        checks++;
        if (busy_cnt != 32) begin
            fails++;
            $display("FAIL clear_busy_cycles: got %0d expected 32", busy_cnt);
        end
        checks++;
        if (clr_done !== 1'b1) begin
            fails++;
            $display("FAIL clear_done_pulse: got %b expected 1", clr_done);
        end
        for (int unsigned a = 0; a < DEPTH; a++) begin
            set_raddr(AW'(a), AW'(a));
            #1;
            checks++;
            if (rdata !== '0) begin
                fails++;
                $display("FAIL clear_entry_zero[%0d]: got %h expected 0", a, rdata);
            end
        end
        @(negedge clk);
        checks++;
        if (clr_done !== 1'b0) begin
            fails++;
            $display("FAIL clear_done_single: got %b expected 0", clr_done);
        end
    endtask

    task automatic test_reset_mid_clear();
        int busy_cnt = 0;
        int done_cnt = 0;
        // Asynchronous assertion from IDLE, away from any clock edge
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b1 || clr_done !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_idle: busy=%b done=%b expected busy=1 done=0", clr_busy, clr_done);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b1 || clr_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_clear_state: busy=%b done=%b expected busy=1 done=0", clr_busy, clr_done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!clr_busy) break;
            busy_cnt++;
            @(negedge clk);
            if (clr_done) done_cnt++;
        end
        checks++;
        if (busy_cnt != 32) begin
            fails++;
            $display("FAIL restart_busy_cycles: got %0d expected 32", busy_cnt);
        end
        checks++;
        if (done_cnt != 1 || clr_done !== 1'b1) begin
            fails++;
            $display("FAIL restart_done: count=%0d done=%b expected count=1 done=1", done_cnt, clr_done);
        end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_dual_write();
        test_zero_reg();
        test_clear_req();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, fails);
        $fatal(1);
    end

endmodule
